// File: rtl/stopwatch_timer_ctrl.sv
// Four-digit BCD stopwatch / countdown timer: switch synchronisers, edge-triggered
// commands, tick prescaler, lap freeze and seven-segment decode.
module stopwatch_timer_ctrl #(
    parameter int CLK_HZ         = 50_000_000,
    parameter int TICK_HZ        = 1,
    parameter int MAX_MIN        = 59,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sw_start,
    input  logic        sw_stop,
    input  logic        sw_clear,
    input  logic        sw_lap,
    input  logic        sw_load,
    input  logic        sw_down,
    input  logic [15:0] preset,
    output logic [15:0] digits,
    output logic [6:0]  seg1,
    output logic [6:0]  seg2,
    output logic [6:0]  seg3,
    output logic [6:0]  seg4,
    output logic [1:0]  state,
    output logic        tick,
    output logic        wrap,
    output logic        lap_hold,
    output logic        load_err,
    output logic        led
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = $clog2(DIV);

    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, DONE = 2'b11} state_t;

    function automatic logic preset_ok(input logic [15:0] p);
        int mins;
        mins = 10 * int'(p[15:12]) + int'(p[11:8]);
        return (p[15:12] <= 4'd9) && (p[11:8] <= 4'd9) && (p[7:4] <= 4'd5) &&
               (p[3:0] <= 4'd9) && (mins <= MAX_MIN);
    endfunction

    function automatic logic at_top(input logic [15:0] c);
        int mins;
        mins = 10 * int'(c[15:12]) + int'(c[11:8]);
        return (mins == MAX_MIN) && (c[7:0] == 8'h59);
    endfunction

    function automatic logic [15:0] bcd_inc(input logic [15:0] c);
        logic [15:0] r;
        r = c;
        if (c[3:0] != 4'd9) r[3:0] = c[3:0] + 4'd1;
        else begin
            r[3:0] = 4'd0;
            if (c[7:4] != 4'd5) r[7:4] = c[7:4] + 4'd1;
            else begin
                r[7:4] = 4'd0;
                if (at_top(c)) r[15:8] = 8'h00;
                else if (c[11:8] != 4'd9) r[11:8] = c[11:8] + 4'd1;
                else begin
                    r[11:8]  = 4'd0;
                    r[15:12] = c[15:12] + 4'd1;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] bcd_dec(input logic [15:0] c);
        logic [15:0] r;
        r = c;
        if (c[3:0] != 4'd0) r[3:0] = c[3:0] - 4'd1;
        else begin
            r[3:0] = 4'd9;
            if (c[7:4] != 4'd0) r[7:4] = c[7:4] - 4'd1;
            else begin
                r[7:4] = 4'd5;
                if (c[11:8] != 4'd0) r[11:8] = c[11:8] - 4'd1;
                else begin
                    r[11:8]  = 4'd9;
                    r[15:12] = c[15:12] - 4'd1;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b0000000;
        endcase
        return SEG_ACTIVE_LOW ? ~s : s;
    endfunction

    logic [4:0]    sw_raw, sync1, sync2, sync3, cmd;
    logic          down1, down2;
    logic          cmd_start, cmd_stop, cmd_clear, cmd_lap, cmd_load;
    state_t        cur_state, state_nxt;
    logic [15:0]   cnt, cnt_nxt, lap_reg, lap_nxt;
    logic [PW-1:0] presc, presc_nxt;
    logic          mode, mode_nxt, hold_nxt, led_nxt, wrap_nxt, err_nxt;

    assign sw_raw = {sw_load, sw_lap, sw_clear, sw_stop, sw_start};
    assign {cmd_load, cmd_lap, cmd_clear, cmd_stop, cmd_start} = cmd;

    // Synchroniser stage: two flops, then a registered rising-edge pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
            cmd   <= '0;
            down1 <= 1'b0;
            down2 <= 1'b0;
        end else begin
            sync1 <= sw_raw;
            sync2 <= sync1;
            sync3 <= sync2;
            cmd   <= sync2 & ~sync3;
            down1 <= sw_down;
            down2 <= down1;
        end
    end

    // A stop or clear acting this cycle suppresses the count instant.
    assign tick = (cur_state == RUN) && (presc == PW'(DIV - 1)) && !cmd_clear && !cmd_stop;

    always_comb begin
        state_nxt = cur_state;
        cnt_nxt   = cnt;
        lap_nxt   = lap_reg;
        presc_nxt = presc;
        mode_nxt  = mode;
        hold_nxt  = lap_hold;
        led_nxt   = led;
        wrap_nxt  = 1'b0;
        err_nxt   = 1'b0;
        if (cmd_clear) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            presc_nxt = '0;
            hold_nxt  = 1'b0;
            led_nxt   = 1'b0;
        end else if (cmd_load && cur_state != RUN) begin
            if (preset_ok(preset)) begin
                cnt_nxt   = preset;
                state_nxt = IDLE;
                hold_nxt  = 1'b0;
                led_nxt   = 1'b0;
            end else begin
                err_nxt = 1'b1;
            end
        end else if (cmd_stop && cur_state == RUN) begin
            state_nxt = PAUSE;
            hold_nxt  = 1'b0;
        end else if (cmd_start && cur_state == IDLE) begin
            if (!(down2 && cnt == 16'h0000)) begin
                state_nxt = RUN;
                mode_nxt  = down2;
                presc_nxt = '0;
            end
        end else if (cmd_start && cur_state == PAUSE) begin
            if (!(mode && cnt == 16'h0000)) state_nxt = RUN;
        end else if (cur_state == RUN) begin
            if (cmd_lap) begin
                hold_nxt = !lap_hold;
                if (!lap_hold) lap_nxt = cnt;
            end
            presc_nxt = tick ? '0 : presc + PW'(1);
            if (tick) begin
                led_nxt = !led;
                if (!mode) begin
                    cnt_nxt  = bcd_inc(cnt);
                    wrap_nxt = at_top(cnt);
                end else begin
                    cnt_nxt = bcd_dec(cnt);
                    if (cnt == 16'h0001) begin
                        state_nxt = DONE;
                        hold_nxt  = 1'b0;
                        led_nxt   = 1'b1;
                    end
                end
            end
        end
    end

    // Control/counter register stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_state <= IDLE;
            cnt       <= '0;
            lap_reg   <= '0;
            presc     <= '0;
            mode      <= 1'b0;
            lap_hold  <= 1'b0;
            led       <= 1'b0;
            wrap      <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            cur_state <= state_nxt;
            cnt       <= cnt_nxt;
            lap_reg   <= lap_nxt;
            presc     <= presc_nxt;
            mode      <= mode_nxt;
            lap_hold  <= hold_nxt;
            led       <= led_nxt;
            wrap      <= wrap_nxt;
            load_err  <= err_nxt;
        end
    end

    assign state  = cur_state;
    assign digits = lap_hold ? lap_reg : cnt;
    assign seg1   = seg_of(digits[3:0]);
    assign seg2   = seg_of(digits[7:4]);
    assign seg3   = seg_of(digits[11:8]);
    assign seg4   = seg_of(digits[15:12]);

endmodule

// File: tb/tb_stopwatch_timer_ctrl.sv
// Bench for stopwatch_timer_ctrl: directed test-plan steps followed by random
// switch activity, all checked against a seconds-based reference model.
`timescale 1ns/1ps
module tb_stopwatch_timer_ctrl;
    localparam int CLK_HZ  = 10;
    localparam int TICK_HZ = 1;
    localparam int DIV     = CLK_HZ / TICK_HZ;
    localparam int MAX_MIN = 1;
    localparam int TOP     = MAX_MIN * 60 + 59;
    localparam int C_START = 0, C_STOP = 1, C_CLEAR = 2, C_LAP = 3, C_LOAD = 4;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;
    localparam logic [6:0] SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  sw = '0;
    logic        sw_down = 1'b0;
    logic [15:0] preset = '0;
    logic [15:0] digits;
    logic [6:0]  seg1, seg2, seg3, seg4;
    logic [1:0]  state;
    logic        tick, wrap, lap_hold, load_err, led;

    int n_vec = 0;
    int n_err = 0;

    stopwatch_timer_ctrl #(
        .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .MAX_MIN(MAX_MIN), .SEG_ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .rst(rst),
        .sw_start(sw[C_START]), .sw_stop(sw[C_STOP]), .sw_clear(sw[C_CLEAR]),
        .sw_lap(sw[C_LAP]), .sw_load(sw[C_LOAD]), .sw_down(sw_down),
        .preset(preset), .digits(digits),
        .seg1(seg1), .seg2(seg2), .seg3(seg3), .seg4(seg4),
        .state(state), .tick(tick), .wrap(wrap), .lap_hold(lap_hold),
        .load_err(load_err), .led(led)
    );

    always #5 clk = ~clk;

    // Reference model: time kept as whole seconds, switches as a sample history.
    int         m_state, m_secs, m_lap, m_presc;
    bit         m_mode, m_hold, m_led, m_wrap, m_err;
    logic [4:0] h [4];
    logic [1:0] hd;

    function automatic logic [15:0] to_bcd(input int s);
        int m, r;
        m = s / 60;
        r = s % 60;
        return {4'(m / 10), 4'(m % 10), 4'(r / 10), 4'(r % 10)};
    endfunction

    function automatic int bcd_secs(input logic [15:0] p);
        return (int'(p[15:12]) * 10 + int'(p[11:8])) * 60 + int'(p[7:4]) * 10 + int'(p[3:0]);
    endfunction

    function automatic bit preset_valid(input logic [15:0] p);
        return p[15:12] <= 4'd9 && p[11:8] <= 4'd9 && p[7:4] <= 4'd5 && p[3:0] <= 4'd9 &&
               (int'(p[15:12]) * 10 + int'(p[11:8])) <= MAX_MIN;
    endfunction

    function automatic int pick(input logic [4:0] c, input int st);
        if (c[C_CLEAR]) return C_CLEAR;
        if (c[C_LOAD] && st != S_RUN) return C_LOAD;
        if (c[C_STOP] && st == S_RUN) return C_STOP;
        if (c[C_START] && (st == S_IDLE || st == S_PAUSE)) return C_START;
        if (c[C_LAP] && st == S_RUN) return C_LAP;
        return -1;
    endfunction

    task automatic model_reset();
        m_state = S_IDLE; m_secs = 0; m_lap = 0; m_presc = 0;
        m_mode = 0; m_hold = 0; m_led = 0; m_wrap = 0; m_err = 0;
        for (int i = 0; i < 4; i++) h[i] = '0;
        hd = '0;
    endtask

    task automatic model_edge();
        int  act;
        bit  dn;
        act = pick(h[2] & ~h[3], m_state);
        dn  = hd[1];
        m_wrap = 0;
        m_err  = 0;
        if (act == C_CLEAR) begin
            m_state = S_IDLE; m_secs = 0; m_presc = 0; m_hold = 0; m_led = 0;
        end else if (act == C_LOAD) begin
            if (preset_valid(preset)) begin
                m_secs = bcd_secs(preset); m_state = S_IDLE; m_hold = 0; m_led = 0;
            end else m_err = 1;
        end else if (act == C_STOP) begin
            m_state = S_PAUSE; m_hold = 0;
        end else if (act == C_START) begin
            if (m_state == S_IDLE) begin
                if (!(dn && m_secs == 0)) begin
                    m_state = S_RUN; m_mode = dn; m_presc = 0;
                end
            end else if (!(m_mode && m_secs == 0)) m_state = S_RUN;
        end else if (m_state == S_RUN) begin
            if (act == C_LAP) begin
                if (!m_hold) m_lap = m_secs;
                m_hold = !m_hold;
            end
            if (m_presc == DIV - 1) begin
                m_presc = 0;
                m_led   = !m_led;
                if (!m_mode) begin
                    if (m_secs == TOP) begin m_secs = 0; m_wrap = 1; end
                    else m_secs = m_secs + 1;
                end else begin
                    m_secs = m_secs - 1;
                    if (m_secs == 0) begin m_state = S_DONE; m_hold = 0; m_led = 1; end
                end
            end else m_presc = m_presc + 1;
        end
        h[3] = h[2]; h[2] = h[1]; h[1] = h[0]; h[0] = sw;
        hd = {hd[0], sw_down};
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s at %0t: observed %h expected %h", tag, $time, obs, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        int          p;
        logic        t;
        logic [15:0] d;
        p = pick(h[2] & ~h[3], m_state);
        t = (m_state == S_RUN) && (m_presc == DIV - 1) && p != C_CLEAR && p != C_STOP;
        d = to_bcd(m_hold ? m_lap : m_secs);
        chk(tag,
            {13'b0, state, digits, tick, wrap, lap_hold, load_err, led, seg4, seg3, seg2, seg1},
            {13'b0, 2'(m_state), d, t, m_wrap, m_hold, m_err, m_led,
             SEG_TAB[d[15:12]], SEG_TAB[d[11:8]], SEG_TAB[d[7:4]], SEG_TAB[d[3:0]]});
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst) model_edge();
        @(negedge clk);
        compare_all("cycle");
    endtask

    task automatic cmd_go(input int idx);
        sw[idx] = 1'b1;
        cycle();
        sw[idx] = 1'b0;
        repeat (3) cycle();
    endtask

    task automatic wait_ticks(input int n);
        int got;
        got = 0;
        for (int i = 0; i < (DIV + 2) * n + 4 && got < n; i++) begin
            cycle();
            if (tick) begin
                got++;
                if (got == n) cycle();
            end
        end
        chk("tick_wait", 64'(got), 64'(n));
    endtask

    function automatic logic [15:0] rand_preset();
        logic [31:0] r;
        r = $urandom();
        if ($urandom_range(0, 3) == 0) return r[15:0];
        return to_bcd(int'($urandom_range(0, TOP)));
    endfunction

    initial begin
        int n;
        model_reset();
        #1;
        chk("reset_digits", 64'(digits), 64'(16'h0000));
        chk("reset_state", 64'(state), 64'(2'b00));
        chk("reset_seg", 64'({seg4, seg3, seg2, seg1}), 64'({4{7'b0111111}}));
        chk("reset_flags", 64'({tick, wrap, lap_hold, load_err, led}), 64'(5'b0));
        repeat (2) cycle();
        rst = 1'b1;

        // Up count: 60 ticks reach one minute.
        cmd_go(C_START);
        chk("start_state", 64'(state), 64'(2'b01));
        wait_ticks(60);
        chk("up_60", 64'(digits), 64'(16'h0100));

        // Stop three prescaler counts into a second, then resume.
        cmd_go(C_STOP);
        chk("stop_state", 64'(state), 64'(2'b10));
        repeat (25) cycle();
        chk("pause_hold", 64'(digits), 64'(16'h0100));
        cmd_go(C_START);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!tick && n < 4 * DIV);
        chk("resume_gap", 64'(n), 64'(DIV - 1 - 3));

        // Rollover at MAX_MIN:59.
        cmd_go(C_CLEAR);
        preset = 16'h0159;
        cmd_go(C_LOAD);
        chk("load_0159", 64'(digits), 64'(16'h0159));
        cmd_go(C_START);
        wait_ticks(1);
        chk("wrap_digits", 64'({state, digits, wrap}), 64'({2'b01, 16'h0000, 1'b1}));
        cycle();
        chk("wrap_one_cycle", 64'(wrap), 64'(1'b0));

        // Countdown to expiry.
        cmd_go(C_CLEAR);
        sw_down = 1'b1;
        preset  = 16'h0002;
        cmd_go(C_LOAD);
        cmd_go(C_START);
        wait_ticks(1);
        chk("down_0001", 64'(digits), 64'(16'h0001));
        wait_ticks(1);
        chk("done", 64'({state, digits, led}), 64'({2'b11, 16'h0000, 1'b1}));
        cmd_go(C_START);
        chk("done_start_ignored", 64'(state), 64'(2'b11));
        cmd_go(C_CLEAR);
        chk("done_clear", 64'({state, digits}), 64'({2'b00, 16'h0000}));
        cmd_go(C_START);
        chk("down_zero_start", 64'(state), 64'(2'b00));
        sw_down = 1'b0;

        // Rejected presets.
        preset = 16'h0070;
        cmd_go(C_LOAD);
        chk("err_0070", 64'({load_err, digits}), 64'({1'b1, 16'h0000}));
        cycle();
        chk("err_pulse", 64'(load_err), 64'(1'b0));
        preset = 16'h1a00;
        cmd_go(C_LOAD);
        chk("err_1a00", 64'({load_err, digits}), 64'({1'b1, 16'h0000}));

        // Lap freeze while counting continues.
        preset = 16'h0005;
        cmd_go(C_LOAD);
        cmd_go(C_START);
        cmd_go(C_LAP);
        chk("lap_set", 64'({lap_hold, digits}), 64'({1'b1, 16'h0005}));
        wait_ticks(3);
        chk("lap_frozen", 64'({lap_hold, digits}), 64'({1'b1, 16'h0005}));
        cmd_go(C_LAP);
        chk("lap_release", 64'({lap_hold, digits}), 64'({1'b0, 16'h0008}));
        preset = 16'h0030;
        cmd_go(C_LOAD);
        chk("load_in_run", 64'({state, digits}), 64'({2'b01, 16'h0008}));

        // Clear beats start in the same cycle; async reset mid-run.
        cmd_go(C_CLEAR);
        sw[C_CLEAR] = 1'b1;
        sw[C_START] = 1'b1;
        cycle();
        sw = '0;
        repeat (3) cycle();
        chk("clear_vs_start", 64'({state, digits}), 64'({2'b00, 16'h0000}));
        cmd_go(C_START);
        wait_ticks(2);
        rst = 1'b0;
        model_reset();
        #1;
        chk("async_reset", 64'({state, digits, tick, wrap, lap_hold, load_err, led, seg1}),
            64'({2'b00, 16'h0000, 5'b0, 7'b0111111}));
        repeat (2) cycle();
        rst = 1'b1;

        // Random switch activity.
        for (int i = 0; i < 3000; i++) begin
            cycle();
            if ($urandom_range(0, 11) == 0) sw[C_START] = ~sw[C_START];
            if ($urandom_range(0, 29) == 0) sw[C_STOP]  = ~sw[C_STOP];
            if ($urandom_range(0, 79) == 0) sw[C_CLEAR] = ~sw[C_CLEAR];
            if ($urandom_range(0, 9)  == 0) sw[C_LAP]   = ~sw[C_LAP];
            if ($urandom_range(0, 24) == 0) sw[C_LOAD]  = ~sw[C_LOAD];
            if ($urandom_range(0, 31) == 0) sw_down = ~sw_down;
            if ($urandom_range(0, 40) == 0) preset = rand_preset();
        end
        sw = '0;
        repeat (6) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/stopwatch_timer_ctrl.md
# stopwatch_timer_ctrl

Parametrised successor to the single-mode MM:SS counter: a four-digit BCD stopwatch/countdown timer with an internal tick prescaler, switch synchronisers and edge-triggered commands (start, stop, clear, lap, load). It adds preset loading, countdown with expiry, and lap-freeze display. It sits between the board switches and the four seven-segment displays, and drives the status LED.

## Interface
- CLK_HZ, 50_000_000: input clock frequency.
- TICK_HZ, 1: count rate. DIV = CLK_HZ/TICK_HZ must be an integer ≥ 2.
- MAX_MIN, 59: highest minute value, ≤ 99.
- SEG_ACTIVE_LOW, 0: 1 inverts all segment outputs.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset. One clock; reset is asynchronous and active-low.
- sw_start, sw_stop, sw_clear, sw_lap, sw_load  in  1 each  raw asynchronous switches. Each acts on its rising edge.
- sw_down  in  1  mode level. 0 = count up, 1 = count down. Synchronised; sampled only in IDLE.
- preset  in  16  BCD {min_tens, min_units, sec_tens, sec_units}. Quasi-static.
- digits  out  16  displayed BCD, same packing as preset.
- seg1..seg4  out  7 each  {g,f,e,d,c,b,a} for sec_units, sec_tens, min_units, min_tens.
- state  out  2  IDLE=00, RUN=01, PAUSE=10, DONE=11.
- tick  out  1  one-cycle pulse at each count instant (RUN only).
- wrap  out  1  one-cycle pulse on an up-count rollover.
- lap_hold  out  1  display frozen.
- load_err  out  1  one-cycle pulse when a load is rejected.
- led  out  1  status LED.

## Operation
- Each sw_* input passes through a 2-flop synchroniser, then a rising-edge detector that produces a one-cycle command pulse.
- Same-cycle command priority: clear > load > stop > start > lap. Only the highest-priority valid command acts.
- clear, in any state: counter = 0000, prescaler = 0, state = IDLE, lap_hold = 0, led = 0.
- load, in IDLE/PAUSE/DONE: counter = preset, state = IDLE.
  - A preset is invalid if any digit > 9, sec_tens > 5, or minutes > MAX_MIN.
  - An invalid preset leaves the counter unchanged and pulses load_err.
  - load is ignored in RUN.
- start:
  - IDLE → RUN; the mode is latched from sw_down.
  - PAUSE → RUN.
  - A down-mode start with counter 0000 is ignored.
- stop: RUN → PAUSE. Ignored elsewhere.
- DONE is exited only by clear or load.
- Prescaler:
  - Counts 0..DIV-1 only in RUN and holds its value in PAUSE, so a resume keeps the partial second.
  - tick fires on the cycle the prescaler is at DIV-1.
  - Prescaler is reset to 0 on IDLE→RUN.
- Up count, per tick: BCD increment with carries sec_units 9→0, sec_tens 5→0, then minutes.
  - At MAX_MIN:59 the counter goes to 00:00, wrap pulses, and state stays RUN.
- Down count, per tick: BCD decrement with borrows sec_units 0→9, sec_tens 0→5, then minutes.
  - The tick that reaches 00:00 moves state to DONE on the same edge. No further ticks.
- Lap, in RUN only:
  - First edge sets lap_hold, and digits freeze at the current value while counting continues.
  - Next lap edge, or stop, clear or load, releases it; digits track the counter again.
  - Entering DONE also releases lap_hold.
- digits = lap register when lap_hold = 1, else the counter. seg* decode digits 0-9; codes above 9 blank (all off).
- led:
  - IDLE: 0.
  - RUN: toggles on each tick.
  - PAUSE: holds its value.
  - DONE: 1.

## Timing
- Reset values: state = 00, digits = 0000, seg* = "0" (0111111, or inverted when SEG_ACTIVE_LOW = 1), tick = wrap = lap_hold = load_err = led = 0. Synchroniser flops = 0.
- A switch rising before clk edge k produces a command pulse at edge k+2. state, counter and flags update at edge k+3.
- First tick comes DIV cycles after entering RUN from IDLE. The counter and digits update on the edge that ends the tick cycle.
- wrap and DONE entry align with the counter update edge.
- Reset asserted mid-count clears everything immediately, asynchronously. Operation resumes on the first clk edge after release.

## Test plan
- DIV = 10, up mode: start → tick every 10 cycles; after 60 ticks digits = 0100. Stop, wait 25 cycles, start → next tick arrives after the remaining prescaler count.
- MAX_MIN = 1, preset 0159, up mode: load, start → first tick gives 0000, wrap pulses for 1 cycle, state stays 01.
- Down mode, preset 0002: load, start → 0001, then 0000 with state = 11 and led = 1. A further start is ignored; clear → state = 00, digits = 0000.
- Preset 0070: load → load_err pulses, counter unchanged. Preset 1a00 → rejected the same way. Load while RUN → ignored.
- RUN at 0005, lap → digits stay 0005 for 3 ticks while the counter reaches 0008. Lap again → digits = 0008.
- Clear and start in the same cycle → state = IDLE, digits = 0000. Assert rst mid-RUN → all outputs return to reset values at once.
